if_agc_ctrl: RTL and testbench

//  Automatic gain controller for the IF filter stage. Measures the peak magnitude of the

---
 rtl/if_agc_ctrl.sv | 123 ++++++++++++
 tb/tb_if_agc_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_agc_ctrl.sv
// IF-stage AGC: windowed peak detector driving the if_filter 2-bit gain select,
// with fast attack, slow decay, post-attack hold, and a manual SPI override.
module if_agc_ctrl #(
  parameter int DATA_W    = 6,
  parameter int WIN_LOG2  = 8,
  parameter int HI_THRESH = 24,
  parameter int LO_THRESH = 6,
  parameter int HOLD_WIN  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] if_filt_in,
  input  logic                     agc_en,
  input  logic        [1:0]        gain_spi,
  output logic        [1:0]        gain_out,
  output logic                     gain_update,
  output logic        [DATA_W-2:0] peak_out,
  output logic                     clip_flag
);

  localparam int HOLD_W = $clog2(HOLD_WIN + 1);
  localparam logic [DATA_W-2:0] HI_T = HI_THRESH[DATA_W-2:0];
  localparam logic [DATA_W-2:0] LO_T = LO_THRESH[DATA_W-2:0];
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_WIN[HOLD_W-1:0];
  localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {MANUAL, TRACK, HOLD} state_t;

  state_t              state;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-2:0]   peak;
  logic                clip;

  logic [DATA_W-1:0]   abs_v;
  logic [DATA_W-2:0]   mag;
  logic [DATA_W-2:0]   peak_win;
  logic                full_scale;
  logic                clip_win;
  logic                attack;
  logic                decay;
  logic                win_end;

  // Window statistics include the current sample so the window-end decision
  // sees the final sample in the same cycle.
  always_comb begin
    abs_v      = if_filt_in[DATA_W-1] ? (~if_filt_in + 1'b1) : if_filt_in;
    mag        = abs_v[DATA_W-1] ? '1 : abs_v[DATA_W-2:0];
    full_scale = (if_filt_in == POS_FS) || (if_filt_in == NEG_FS);
    peak_win   = (mag > peak) ? mag : peak;
    clip_win   = clip | full_scale;
    attack     = (peak_win >= HI_T) || clip_win;
    decay      = (peak_win < LO_T);
    win_end    = sample_valid && (win_cnt == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MANUAL;
      gain_out    <= '0;
      gain_update <= 1'b0;
      peak_out    <= '0;
      clip_flag   <= 1'b0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      peak        <= '0;
      clip        <= 1'b0;
    end else begin
      gain_update <= 1'b0;
      case (state)
        MANUAL: begin
          win_cnt  <= '0;
          hold_cnt <= '0;
          peak     <= '0;
          clip     <= 1'b0;
          if (agc_en) begin
            state <= TRACK;
          end else begin
            gain_out    <= gain_spi;
            gain_update <= (gain_spi != gain_out);
          end
        end
        default: begin
          if (!agc_en) begin
            state    <= MANUAL;
            win_cnt  <= '0;
            hold_cnt <= '0;
            peak     <= '0;
            clip     <= 1'b0;
          end else if (sample_valid) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
              peak      <= '0;
              clip      <= 1'b0;
              peak_out  <= peak_win;
              clip_flag <= clip_win;
              if (attack) begin
                if (gain_out != 2'd0) begin
                  gain_out    <= gain_out - 2'd1;
                  gain_update <= 1'b1;
                end
                state    <= HOLD;
                hold_cnt <= HOLD_INIT;
              end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == HOLD_W'(1)) state <= TRACK;
              end else if (decay && gain_out != 2'd3) begin
                gain_out    <= gain_out + 2'd1;
                gain_update <= 1'b1;
              end
            end else begin
              peak <= peak_win;
              clip <= clip_win;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_agc_ctrl.sv
// Directed bench for if_agc_ctrl with 16-sample windows; expected values hand-derived.
module tb_if_agc_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic signed [5:0] if_filt_in;
  logic              agc_en;
  logic [1:0]        gain_spi;
  logic [1:0]        gain_out;
  logic              gain_update;
  logic [4:0]        peak_out;
  logic              clip_flag;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  if_agc_ctrl #(.DATA_W(6), .WIN_LOG2(4), .HI_THRESH(24), .LO_THRESH(6), .HOLD_WIN(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .if_filt_in(if_filt_in),
    .agc_en(agc_en), .gain_spi(gain_spi), .gain_out(gain_out),
    .gain_update(gain_update), .peak_out(peak_out), .clip_flag(clip_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [5:0] s);
    sample_valid = 1'b1;
    if_filt_in   = s;
    tick();
    sample_valid = 1'b0;
  endtask

  // Alternating +/-amp, with one idle gap mid-window; first/last may be overridden.
  task automatic send_n(input int n, input logic signed [5:0] amp);
    for (int i = 0; i < n; i++) begin
      send((i % 2 == 0) ? amp : -amp);
      if (i == 5) tick();
    end
  endtask

  task automatic check_win(input string tag, input logic [1:0] g, input logic u,
                           input logic [4:0] p, input logic c);
    chk({tag, "_gain"}, 32'(gain_out), 32'(g));
    chk({tag, "_upd"},  32'(gain_update), 32'(u));
    chk({tag, "_peak"}, 32'(peak_out), 32'(p));
    chk({tag, "_clip"}, 32'(clip_flag), 32'(c));
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; if_filt_in = '0; agc_en = 1'b0; gain_spi = 2'd0;
    tick(); tick();
    check_win("reset", 2'd0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();

    // 1: manual gain follows SPI with one cycle latency
    gain_spi = 2'd2;
    chk("man_lat", 32'(gain_out), 32'd0);
    tick();
    chk("man_gain", 32'(gain_out), 32'd2);
    chk("man_upd", 32'(gain_update), 32'd1);
    tick();
    chk("man_upd_off", 32'(gain_update), 32'd0);

    // 2: enter AGC at gain 2, low window raises to 3, further low windows saturate
    agc_en = 1'b1;
    tick();
    chk("entry_gain", 32'(gain_out), 32'd2);
    chk("entry_upd", 32'(gain_update), 32'd0);
    send_n(15, 6'sd3);
    chk("pre_end_gain", 32'(gain_out), 32'd2);
    chk("pre_end_peak", 32'(peak_out), 32'd0);
    send(-6'sd3);
    check_win("low1", 2'd3, 1'b1, 5'd3, 1'b0);
    tick();
    chk("low1_upd_off", 32'(gain_update), 32'd0);
    send_n(16, 6'sd3);
    check_win("low_sat", 2'd3, 1'b0, 5'd3, 1'b0);

    // 3: single -32 sample clips, attack to 2, hold 4 windows, then decay to 3
    send(-6'sd32);
    send_n(15, 6'sd2);
    check_win("clip", 2'd2, 1'b1, 5'd31, 1'b1);
    for (int w = 0; w < 4; w++) begin
      send_n(16, 6'sd2);
      check_win("hold", 2'd2, 1'b0, 5'd2, 1'b0);
    end
    send_n(16, 6'sd2);
    check_win("hold_exit", 2'd3, 1'b1, 5'd2, 1'b0);

    // 4: window end with peak 24 while agc_en drops: no evaluation
    gain_spi = 2'd1;
    send_n(15, 6'sd2);
    agc_en = 1'b0;
    send(6'sd24);
    chk("dis_gain", 32'(gain_out), 32'd3);
    chk("dis_peak", 32'(peak_out), 32'd2);
    tick();
    check_win("dis_man", 2'd1, 1'b1, 5'd2, 1'b0);

    // 5: asynchronous reset mid-window, then a between-thresholds window
    agc_en = 1'b1;
    tick();
    send_n(9, 6'sd30);
    #2 rst = 1'b1;
    #1;
    check_win("async_rst", 2'd0, 1'b0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    send_n(15, 6'sd10);
    chk("post_rst_no_early", 32'(peak_out), 32'd0);
    send(-6'sd10);
    check_win("mid", 2'd0, 1'b0, 5'd10, 1'b0);

    // 6: attacks at gain 0: no underflow, no pulses, hold re-armed by the last one
    send_n(16, 6'sd31);
    check_win("atk0_a", 2'd0, 1'b0, 5'd31, 1'b1);
    send(-6'sd31);
    send_n(15, 6'sd25);
    check_win("atk0_b", 2'd0, 1'b0, 5'd31, 1'b0);
    send_n(16, 6'sd31);
    check_win("atk0_c", 2'd0, 1'b0, 5'd31, 1'b1);
    for (int w = 0; w < 4; w++) begin
      send_n(16, 6'sd1);
      check_win("rearm_hold", 2'd0, 1'b0, 5'd1, 1'b0);
    end
    send_n(16, 6'sd1);
    check_win("rearm_exit", 2'd1, 1'b1, 5'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
